// File: rtl/apb_pkg.sv
// Shared APB definitions for the bridge and its neighbours.
// Holds the requester state enum, default bus widths, and the command and
// response record types used where the bridge is wrapped in a larger fabric.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mst_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge.sv
// APB3 requester: turns a valid/ready command stream into SETUP/ACCESS
// transfers, one outstanding at a time, and returns one response pulse
// per command. A wait counter bounds how long ACCESS waits for pready.
//
// Ports:
//   pclk, preset                 clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata   command stream (accepted in IDLE only)
//   rsp_valid/rdata/err          one-cycle completion pulse, data/err held
//   psel/penable/pwrite/paddr/pwdata   APB request outputs (registered)
//   prdata/pready/pslverr        APB responder inputs
//
// state  | meaning
// IDLE   | no transfer; cmd_ready high, waiting for a command
// SETUP  | first APB phase; psel high, penable low, exactly one cycle
// ACCESS | psel and penable high; waiting for pready or timeout
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_mst_state_e    state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                // pready is checked first so a response on the last allowed
                // cycle completes normally instead of timing out.
                if (pready) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = IDLE;
                end else if (wait_cnt_q == CNT_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester (initiator) that converts a simple valid/ready command stream into APB3 SETUP/ACCESS transfers and returns one response per command.
- Drives the bus toward apb_slave-class responders.
- Used in RTL as the CPU-side bridge and in the bench as a reference requester.
- Single outstanding transfer; bounded wait states via a timeout counter.

Parameters:
- ADDR_W, 8, width of paddr / cmd_addr
- DATA_W, 8, width of pwdata / prdata / cmd_wdata / rsp_rdata
- TIMEOUT, 16, max ACCESS cycles waiting for pready before forced error completion (>=2)

Ports:
- pclk  in  1  clock
- preset  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
- rsp_err  out  1  pslverr or timeout on this transfer
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  responder ready
- pslverr  in  1  responder error

Behaviour:
- One clock, pclk. Reset is synchronous, active-high on preset. All outputs are registered.
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, wait counter=0. cmd_ready=1 is a decode of IDLE.
- FSM states (shared enum): IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch cmd_write/addr/wdata into pwrite/paddr/pwdata; psel<=1, penable<=0; go to SETUP.
  - Without a handshake, psel=0 and penable=0.
- SETUP (exactly 1 cycle): penable<=1; wait counter<=0; go to ACCESS.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held stable.
  - pready=1: complete. rsp_valid<=1 next cycle; rsp_err<=pslverr; rsp_rdata<=prdata if read, else 0. psel<=0, penable<=0; go to IDLE.
  - pready=0 with counter==TIMEOUT-1: complete with rsp_err<=1, rsp_rdata<=0. Drop psel/penable; go to IDLE.
  - Otherwise: counter increments.
- Latency:
  - Zero-wait transfer: handshake at cycle N, SETUP N+1, ACCESS N+2, rsp_valid at N+3.
  - Each wait state adds 1 cycle.
  - cmd_ready returns 1 in cycle N+3, so back-to-back throughput is 1 transfer per 3 cycles.
- rsp_valid is a single-cycle pulse with no backpressure; the consumer must sample it. rsp_rdata and rsp_err hold until the next completion.
- pslverr is sampled only when pready=1 in ACCESS; it is ignored at all other times.
- The cmd_* inputs are ignored outside IDLE.
- Reset mid-transfer: next edge forces IDLE and deasserts psel/penable. No response is generated for the aborted transfer.
- Simultaneous pready and timeout boundary: pready wins, giving a normal completion.

Decomposition:
- apb_pkg gains:
  - apb_mst_state_e (IDLE/SETUP/ACCESS)
  - APB_ADDR_W/APB_DATA_W defaults
  - apb_cmd_t struct (write, addr, wdata)
  - apb_rsp_t struct (rdata, err)
- No sub-module. The wait counter is inline, width $clog2(TIMEOUT).

Test Plan:
- Write 0x5A to addr 0x10, pready tied 1 -> psel rises at N+1, penable at N+2, pwdata=0x5A, rsp_valid at N+3, rsp_err=0.
- Read addr 0x10 after that write, against apb_slave -> rsp_rdata=0x5A, rsp_err=0, paddr/pwrite stable through SETUP and ACCESS.
- Read with pready held low 3 ACCESS cycles, prdata=0xC3 on the 4th -> rsp_valid at N+6, rsp_rdata=0xC3, penable high 4 cycles.
- pready stuck 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, then rsp_err=1, rsp_rdata=0, psel=0, cmd_ready=1.
- pready=1 with pslverr=1 on write -> rsp_err=1; next command accepted normally with rsp_err=0.
- preset asserted during ACCESS -> next cycle psel=0, penable=0, cmd_ready=1, no rsp_valid. Also cmd_valid held high for 3 commands -> handshakes exactly 3 cycles apart.
